disp_counter_param: RTL and testbench
=====================================

Name: disp_counter_param

Overview:
Parametrised display counter. A W-bit universal up/down counter with load and synchronous clear drives an NDIG-digit multiplexed seven-segment display. The display shows the count in hex or, through a sequential shift-add-3 converter, in decimal. It sits at board top level between switch/button debouncers and the seven-segment pins.

Parameters:
W, 8, counter width (2..16)
NDIG, 4, number of display digits (2..8)
REFRESH_BITS, 18, digit-advance prescaler width (sim: 4)

Ports:
clk  in  1  system clock
reset  in  1  synchronous, active-high reset
en  in  1  count enable
up  in  1  1 = count up, 0 = count down
d  in  W  parallel load value
syn_clr  in  1  synchronous clear
load  in  1  parallel load
dec_mode  in  1  1 = decimal display, 0 = hex display
q  out  W  counter value
max_tick  out  1  q == 2^W-1
min_tick  out  1  q == 0
busy  out  1  decimal converter running
ovf  out  1  decimal value does not fit in NDIG digits
an  out  NDIG  digit enables, one-hot active-low
sseg  out  8  segments; [6:0]=gfedcba and [7]=dp, all active-low

Behaviour:
- Reset (reset=1 at posedge): q=0, digit registers=0, converter IDLE, busy=0, ovf=0, prescaler=0, digit index=0, an=~1 (only digit 0 on), sseg=8'hC0 ('0').
- Counter priority per cycle: syn_clr > load > en. syn_clr sets q=0. load sets q=d. With en: up increments, down decrements, modulo 2^W; wraps 2^W-1→0 and 0→2^W-1. None asserted: hold.
- max_tick and min_tick are combinational from q.
- Hex mode: digit registers take the nibbles of q one cycle after q changes. Digits above ceil(W/4) show 0. ovf=0.
- Decimal converter FSM: IDLE→SHIFT→DONE→IDLE.
  - IDLE: if dec_mode=1 and q != snapshot, latch snapshot=q and go to SHIFT. busy=1 from the next cycle.
  - SHIFT: W iterations, one per cycle. Each iteration adds 3 to every BCD nibble ≥5, then shifts left one bit.
  - DONE: one cycle. Copy BCD result to digit registers, compute ovf, then return to IDLE with busy=0.
  - Latency from q change to display update: W+2 cycles.
  - q changes during SHIFT are ignored until IDLE, where they are re-detected. The display never shows partial results.
- Mode switches:
  - Entering decimal mode forces a conversion. Snapshot is invalidated on the dec_mode rising edge.
  - Leaving decimal mode mid-conversion aborts to IDLE. busy=0 next cycle and hex digits load.
- ovf=1 when the BCD result has a nonzero digit at index ≥ NDIG. While ovf=1, the low NDIG digits are shown and every dp is lit.
- Mux:
  - The prescaler runs freely. On wrap to 0, the digit index advances and wraps at NDIG-1→0.
  - an and sseg are registered and change on the same edge, so there is no ghosting.
  - Hex digit codes follow the standard 0-F seven-segment table.
- Reset mid-conversion returns to IDLE with the outputs at their reset values.

Optional Feature:
LEADING_ZERO_BLANK_EN.
- Defined: leading zero digits above digit 0 are blanked (sseg=8'hFF, dp unaffected). Digit 0 is always shown. Blanking is computed from the committed digit registers.
- Undefined: all NDIG digits are shown, including leading zeros.

Decomposition:
- Package disp_pkg holds:
  - the SSEG_HEX[16] segment-code constant
  - SSEG_BLANK=8'hFF
  - the converter state typedef {CV_IDLE, CV_SHIFT, CV_DONE}
  - the function clog2 for the index and BCD widths.
- Sub-module bin2bcd_seq(W, NDIG_OUT) implements the converter FSM. Ports: start, bin, busy, done, bcd.
- The counter, digit registers, prescaler and mux stay in the top module.

Test Plan:
- Bench config W=8, NDIG=4, REFRESH_BITS=4.
- reset, then en=1, up=1 for 255 cycles → q=255 and max_tick=1; one more cycle → q=0 and min_tick=1.
- load=1, d=8'hA7, dec_mode=0 → q=8'hA7; after 1 cycle digits {0,0,A,7}; an sequence 1110→1101→1011→0111, advancing every 16 cycles.
- dec_mode=1 with q=167 → busy=1 for W+1 cycles; digits become {0,1,6,7} exactly 10 cycles after the mode edge.
- syn_clr=1, load=1, en=1 in the same cycle → q=0; in the next cycle, en=1, up=0 → q=255.
- NDIG=2, dec_mode=1, q=200 → ovf=1, digits show {0,0}, dp lit on both. With LEADING_ZERO_BLANK_EN and q=5: digit1 sseg=8'hFF and digit0 shows '5'.
- reset asserted during SHIFT → busy=0, q=0, sseg=8'hC0 and an=~1 on the next cycle.

Source files
------------

// File: rtl/disp_pkg.sv
// Shared segment codes, converter state type and width helpers for the display counter.
// Pure declarations: no latency, no flow control.
package disp_pkg;

  // Active-low {dp, g, f, e, d, c, b, a}; dp is off in every entry.
  localparam logic [7:0] SSEG_HEX [16] = '{
    8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99, 8'h92, 8'h82, 8'hF8,
    8'h80, 8'h90, 8'h88, 8'h83, 8'hC6, 8'hA1, 8'h86, 8'h8E
  };
  localparam logic [7:0] SSEG_BLANK = 8'hFF;

  typedef enum logic [1:0] {CV_IDLE, CV_SHIFT, CV_DONE} cv_state_t;

  function automatic int clog2(input int v);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < v) r = i + 1;
    end
    return r;
  endfunction

  // Number of decimal digits needed for the largest w-bit value.
  function automatic int dec_digits(input int w);
    int v;
    int n;
    v = (1 << w) - 1;
    n = 1;
    for (int i = 0; i < 10; i++) begin
      if (v >= 10) begin
        v = v / 10;
        n = n + 1;
      end
    end
    return n;
  endfunction

endpackage

// File: rtl/bin2bcd_seq.sv
// Sequential shift-add-3 binary-to-BCD converter; W SHIFT cycles then one DONE cycle.
// start is accepted only in IDLE (busy=0); bcd holds the last result until the next start.
module bin2bcd_seq
  import disp_pkg::*;
#(
  parameter int W        = 8,
  parameter int NDIG_OUT = 3
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  input  logic [W-1:0]          bin,
  output logic                  busy,
  output logic                  done,
  output logic [4*NDIG_OUT-1:0] bcd
);

  localparam int CW = (clog2(W) < 1) ? 1 : clog2(W);

  cv_state_t             r_state;
  cv_state_t             w_state_nxt;
  logic [W-1:0]          r_bin;
  logic [4*NDIG_OUT-1:0] r_bcd;
  logic [4*NDIG_OUT-1:0] w_adj;
  logic [CW-1:0]         r_cnt;
  logic                  w_last;

  assign w_last = (r_cnt == CW'(W - 1));

  always_ff @(posedge clk) begin
    if (reset) r_state <= CV_IDLE;
    else       r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      CV_IDLE:  if (start)  w_state_nxt = CV_SHIFT;
      CV_SHIFT: if (w_last) w_state_nxt = CV_DONE;
      CV_DONE:  w_state_nxt = CV_IDLE;
      default:  w_state_nxt = CV_IDLE;
    endcase
  end

  // Add-3 correction on every nibble >= 5 before each left shift.
  always_comb begin
    w_adj = r_bcd;
    for (int k = 0; k < NDIG_OUT; k++) begin
      if (r_bcd[4*k +: 4] >= 4'd5) w_adj[4*k +: 4] = r_bcd[4*k +: 4] + 4'd3;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_bin <= '0;
      r_bcd <= '0;
      r_cnt <= '0;
    end else if (r_state == CV_IDLE && start) begin
      r_bin <= bin;
      r_bcd <= '0;
      r_cnt <= '0;
    end else if (r_state == CV_SHIFT) begin
      {r_bcd, r_bin} <= {w_adj[4*NDIG_OUT-2:0], r_bin, 1'b0};
      r_cnt          <= r_cnt + 1'b1;
    end
  end

  assign busy = (r_state != CV_IDLE);
  assign done = (r_state == CV_DONE);
  assign bcd  = r_bcd;

endmodule

// File: rtl/disp_counter_param.sv
// Up/down counter driving a multiplexed hex/decimal 7-seg display; decimal update W+2 cycles after q.
// No backpressure: q changes seen mid-conversion are re-detected later. LEADING_ZERO_BLANK_EN blanks leading zeros.
module disp_counter_param
  import disp_pkg::*;
#(
  parameter int W            = 8,
  parameter int NDIG         = 4,
  parameter int REFRESH_BITS = 18
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            en,
  input  logic            up,
  input  logic [W-1:0]    d,
  input  logic            syn_clr,
  input  logic            load,
  input  logic            dec_mode,
  output logic [W-1:0]    q,
  output logic            max_tick,
  output logic            min_tick,
  output logic            busy,
  output logic            ovf,
  output logic [NDIG-1:0] an,
  output logic [7:0]      sseg
);

  localparam int NH   = (W + 3) / 4;
  localparam int NBCD = dec_digits(W);
  localparam int IDXW = clog2(NDIG);
  localparam int QXW  = 4 * NH;

  logic [W-1:0]            r_q;
  logic [W-1:0]            r_snap;
  logic                    r_snap_vld;
  logic [3:0]              r_dig [NDIG];
  logic                    r_ovf;
  logic [REFRESH_BITS-1:0] r_pre;
  logic [IDXW-1:0]         r_idx;
  logic [IDXW-1:0]         w_idx_nxt;
  logic [NDIG-1:0]         r_an;
  logic [7:0]              r_sseg;
  logic                    w_start;
  logic                    w_cv_rst;
  logic                    w_cv_busy;
  logic                    w_cv_done;
  logic [4*NBCD-1:0]       w_bcd;
  logic [QXW-1:0]          w_q_ext;
  logic [3:0]              w_hex_dig [NDIG];
  logic [3:0]              w_bcd_dig [NDIG];
  logic [NBCD-1:0]         w_ovf_vec;
  logic [NDIG-1:0]         w_blank;
  logic [3:0]              w_cur_dig;
  logic [7:0]              w_sseg_nxt;

  always_ff @(posedge clk) begin
    if (reset)        r_q <= '0;
    else if (syn_clr) r_q <= '0;
    else if (load)    r_q <= d;
    else if (en)      r_q <= up ? r_q + 1'b1 : r_q - 1'b1;
  end

  assign q        = r_q;
  assign max_tick = &r_q;
  assign min_tick = ~|r_q;

  // Leaving decimal mode holds the converter in reset, which doubles as the abort path.
  assign w_cv_rst = reset | ~dec_mode;
  assign w_start  = dec_mode & ~w_cv_busy & (~r_snap_vld | (r_q != r_snap));

  always_ff @(posedge clk) begin
    if (reset) begin
      r_snap     <= '0;
      r_snap_vld <= 1'b0;
    end else if (!dec_mode) begin
      r_snap_vld <= 1'b0;
    end else if (w_start) begin
      r_snap     <= r_q;
      r_snap_vld <= 1'b1;
    end
  end

  bin2bcd_seq #(
    .W        (W),
    .NDIG_OUT (NBCD)
  ) u_bin2bcd (
    .clk   (clk),
    .reset (w_cv_rst),
    .start (w_start),
    .bin   (r_q),
    .busy  (w_cv_busy),
    .done  (w_cv_done),
    .bcd   (w_bcd)
  );

  assign busy    = w_cv_busy;
  assign w_q_ext = QXW'(r_q);

  for (genvar gi = 0; gi < NDIG; gi++) begin : g_dig
    if (gi < NH) begin : g_hex
      assign w_hex_dig[gi] = w_q_ext[4*gi +: 4];
    end else begin : g_hex_zero
      assign w_hex_dig[gi] = 4'h0;
    end
    if (gi < NBCD) begin : g_bcd
      assign w_bcd_dig[gi] = w_bcd[4*gi +: 4];
    end else begin : g_bcd_zero
      assign w_bcd_dig[gi] = 4'h0;
    end
  end

  // BCD digits that do not fit on the display flag overflow.
  for (genvar gj = 0; gj < NBCD; gj++) begin : g_ovf
    if (gj >= NDIG) begin : g_hi
      assign w_ovf_vec[gj] = |w_bcd[4*gj +: 4];
    end else begin : g_lo
      assign w_ovf_vec[gj] = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < NDIG; i++) r_dig[i] <= 4'h0;
      r_ovf <= 1'b0;
    end else if (!dec_mode) begin
      for (int i = 0; i < NDIG; i++) r_dig[i] <= w_hex_dig[i];
      r_ovf <= 1'b0;
    end else if (w_cv_done) begin
      for (int i = 0; i < NDIG; i++) r_dig[i] <= w_bcd_dig[i];
      r_ovf <= |w_ovf_vec;
    end
  end

  assign ovf = r_ovf;

  always_comb begin : p_blank
    logic v_hi_zero;
    w_blank   = '0;
    v_hi_zero = 1'b1;
`ifdef LEADING_ZERO_BLANK_EN
    for (int i = NDIG - 1; i >= 1; i--) begin
      v_hi_zero  = v_hi_zero & (r_dig[i] == 4'h0);
      w_blank[i] = v_hi_zero;
    end
`endif
  end

  always_comb begin
    w_idx_nxt = r_idx;
    if (&r_pre) w_idx_nxt = (r_idx == IDXW'(NDIG - 1)) ? '0 : r_idx + 1'b1;
  end

  always_comb begin
    w_cur_dig  = r_dig[w_idx_nxt];
    w_sseg_nxt = {~r_ovf, w_blank[w_idx_nxt] ? SSEG_BLANK[6:0] : SSEG_HEX[w_cur_dig][6:0]};
  end

  // Anode and segment registers share one edge so a digit never shows its neighbour's code.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_pre  <= '0;
      r_idx  <= '0;
      r_an   <= ~NDIG'(1);
      r_sseg <= SSEG_HEX[0];
    end else begin
      r_pre  <= r_pre + 1'b1;
      r_idx  <= w_idx_nxt;
      r_an   <= ~(NDIG'(1) << w_idx_nxt);
      r_sseg <= w_sseg_nxt;
    end
  end

  assign an   = r_an;
  assign sseg = r_sseg;

endmodule

// File: tb/tb_disp_counter_param.sv
// Bench for disp_counter_param: a 4-digit and a 2-digit instance share stimulus and are
// compared every cycle against an arithmetic reference model.
module tb_disp_counter_param;

  localparam int W  = 8;
  localparam int RB = 4;
  localparam logic [7:0] SEG [16] = '{
    8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99, 8'h92, 8'h82, 8'hF8,
    8'h80, 8'h90, 8'h88, 8'h83, 8'hC6, 8'hA1, 8'h86, 8'h8E
  };

  logic       clk = 1'b0;
  logic       reset, en, up, syn_clr, load, dec_mode;
  logic [7:0] d;
  logic [7:0] q0, q1, s0, s1;
  logic       mx0, mx1, mn0, mn1, b0, b1, o0, o1;
  logic [3:0] an0;
  logic [1:0] an1;

  int n_vec  = 0;
  int n_miss = 0;

  int m_q, m_cyc, m_left, m_snap, m_val;
  bit m_snap_vld;
  int m_dig [2][4];
  bit m_ovf [2];
  int m_an [2];
  int m_sseg [2];

  always #5 clk = ~clk;

  disp_counter_param #(.W(W), .NDIG(4), .REFRESH_BITS(RB)) u_dut4 (
    .clk(clk), .reset(reset), .en(en), .up(up), .d(d), .syn_clr(syn_clr),
    .load(load), .dec_mode(dec_mode), .q(q0), .max_tick(mx0), .min_tick(mn0),
    .busy(b0), .ovf(o0), .an(an0), .sseg(s0)
  );

  disp_counter_param #(.W(W), .NDIG(2), .REFRESH_BITS(RB)) u_dut2 (
    .clk(clk), .reset(reset), .en(en), .up(up), .d(d), .syn_clr(syn_clr),
    .load(load), .dec_mode(dec_mode), .q(q1), .max_tick(mx1), .min_tick(mn1),
    .busy(b1), .ovf(o1), .an(an1), .sseg(s1)
  );

  function automatic int disp_code(input int k, input int idx);
    int seg;
`ifdef LEADING_ZERO_BLANK_EN
    int hi;
    hi = 0;
    for (int i = 0; i < ((k == 0) ? 4 : 2); i++) if (m_dig[k][i] != 0) hi = i;
`endif
    seg = int'(SEG[m_dig[k][idx]]) & 'h7F;
`ifdef LEADING_ZERO_BLANK_EN
    if (idx > hi) seg = 'h7F;
`endif
    return seg | (m_ovf[k] ? 0 : 'h80);
  endfunction

  always @(posedge clk) begin : p_model
    int nd, idx, p;
    if (reset) begin
      m_q = 0; m_cyc = 0; m_left = 0; m_snap_vld = 0;
      for (int k = 0; k < 2; k++) begin
        m_ovf[k]  = 0;
        m_an[k]   = (k == 0) ? 'hE : 'h2;
        m_sseg[k] = 'hC0;
        for (int i = 0; i < 4; i++) m_dig[k][i] = 0;
      end
    end else begin
      m_cyc++;
      for (int k = 0; k < 2; k++) begin
        nd        = (k == 0) ? 4 : 2;
        idx       = (m_cyc / (1 << RB)) % nd;
        m_an[k]   = ~(1 << idx) & ((1 << nd) - 1);
        m_sseg[k] = disp_code(k, idx);
      end
      if (!dec_mode) begin
        m_left = 0; m_snap_vld = 0;
        for (int k = 0; k < 2; k++) begin
          m_ovf[k] = 0;
          for (int i = 0; i < 4; i++) m_dig[k][i] = (m_q >> (4 * i)) & 15;
        end
      end else if (m_left > 0) begin
        m_left--;
        if (m_left == 0) begin
          for (int k = 0; k < 2; k++) begin
            nd = (k == 0) ? 4 : 2;
            p  = 1;
            for (int i = 0; i < nd; i++) begin
              m_dig[k][i] = (m_val / p) % 10;
              p = p * 10;
            end
            m_ovf[k] = (m_val >= p);
          end
        end
      end else if (!m_snap_vld || m_q != m_snap) begin
        m_snap = m_q; m_snap_vld = 1; m_val = m_q; m_left = W + 1;
      end
      if (syn_clr)   m_q = 0;
      else if (load) m_q = d;
      else if (en)   m_q = up ? (m_q + 1) % 256 : (m_q + 255) % 256;
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_miss++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    check("q4", q0, m_q);
    check("q2", q1, m_q);
    check("max4", mx0, m_q == 255);
    check("min4", mn0, m_q == 0);
    check("max2", mx1, m_q == 255);
    check("min2", mn1, m_q == 0);
    check("busy4", b0, m_left > 0);
    check("busy2", b1, m_left > 0);
    check("ovf4", o0, m_ovf[0]);
    check("ovf2", o1, m_ovf[1]);
    check("an4", an0, m_an[0]);
    check("an2", an1, m_an[1]);
    check("sseg4", s0, m_sseg[0]);
    check("sseg2", s1, m_sseg[1]);
  endtask

  initial begin
    int bc;
    reset = 1; en = 0; up = 1; syn_clr = 0; load = 0; dec_mode = 0; d = 0;
    tick(); tick();
    check("rst_q", q0, 0);
    check("rst_an", an0, 4'hE);
    check("rst_sseg", s0, 8'hC0);
    check("rst_busy", b0, 0);
    reset = 0;

    en = 1; up = 1;
    repeat (255) tick();
    check("up255_q", q0, 255);
    check("up255_max", mx0, 1);
    tick();
    check("wrap_q", q0, 0);
    check("wrap_min", mn0, 1);

    en = 0; load = 1; d = 8'hA7;
    tick();
    check("load_q", q0, 8'hA7);
    load = 0;
    repeat (70) tick();

    dec_mode = 1; bc = 0;
    repeat (12) begin
      tick();
      if (b0) bc++;
    end
    check("busy_len", bc, W + 1);
    for (int c = 0; c < 64; c++) begin
      tick();
      case (an0)
        4'hE:    check("dec167_d0", s0, 8'hF8);
        4'hD:    check("dec167_d1", s0, 8'h82);
        4'hB:    check("dec167_d2", s0, 8'hF9);
`ifdef LEADING_ZERO_BLANK_EN
        4'h7:    check("dec167_d3", s0, 8'hFF);
`else
        4'h7:    check("dec167_d3", s0, 8'hC0);
`endif
        default: check("an_onehot", an0, 4'hE);
      endcase
    end

    syn_clr = 1; load = 1; en = 1; d = 8'h55;
    tick();
    check("clr_pri", q0, 0);
    syn_clr = 0; load = 0; up = 0;
    tick();
    check("dn_wrap", q0, 255);
    en = 0; up = 1;
    repeat (12) tick();

    load = 1; d = 8'd200;
    tick();
    load = 0;
    repeat (12) tick();
    check("ovf_n2", o1, 1);
    check("ovf_n4", o0, 0);
    repeat (40) tick();
    check("ovf_dp", s1[7], 0);

    load = 1; d = 8'd5;
    tick();
    load = 0;
    repeat (44) tick();

    load = 1; d = 8'h9A;
    tick();
    load = 0;
    repeat (3) tick();
    check("shift_busy", b0, 1);
    reset = 1;
    tick();
    check("rs_busy", b0, 0);
    check("rs_q", q0, 0);
    check("rs_sseg", s0, 8'hC0);
    check("rs_an", an0, 4'hE);
    reset = 0;

    repeat (3000) begin
      en      = ($urandom_range(0, 3) == 0);
      up      = 1'($urandom_range(0, 1));
      load    = ($urandom_range(0, 19) == 0);
      syn_clr = ($urandom_range(0, 39) == 0);
      d       = 8'($urandom_range(0, 255));
      if ($urandom_range(0, 59) == 0) dec_mode = ~dec_mode;
      reset   = ($urandom_range(0, 399) == 0);
      tick();
    end
    reset = 0;
    tick();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
